// File: rtl/adc_reading_filter_if.sv
// Sample/result bundle between the ADC front end and the moving-average filter.
// The master drives raw samples and the flush strobe; the slave is the filter.
interface adc_reading_filter_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_in_valid;
    logic                  clear;
    logic [DATA_WIDTH-1:0] filtered_out;
    logic                  filtered_valid;
    logic                  primed;

    modport master (
        output sample_in, sample_in_valid, clear,
        input  filtered_out, filtered_valid, primed
    );

    modport slave (
        input  sample_in, sample_in_valid, clear,
        output filtered_out, filtered_valid, primed
    );
endinterface

// File: rtl/adc_reading_filter.sv
// Boxcar moving-average filter: a ring buffer of the last 2**LOG2_DEPTH ADC
// samples plus a running sum, emitting the floor mean on each accepted sample.
module adc_reading_filter #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_reading_filter_if.slave   bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_WIDTH + LOG2_DEPTH;

    localparam logic [0:0] FILLING = 1'b0;
    localparam logic [0:0] PRIMED  = 1'b1;

    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] ring [DEPTH];
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      new_sum;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH:0]   fill_count;
    logic [LOG2_DEPTH:0]   fill_next;
    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] oldest;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  valid_q;
    logic                  accept;

    assign accept = bus.sample_in_valid && !bus.clear && !reset;

    // During fill the evicted slot holds stale RAM, so it contributes zero.
    always_comb begin
        oldest    = '0;
        new_sum   = '0;
        fill_next = fill_count;
        if (state == PRIMED) oldest = ring[wr_ptr];
        new_sum = sum + SUM_W'(bus.sample_in) - SUM_W'(oldest);
        if (fill_count != FULL_COUNT) fill_next = fill_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum        <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            state      <= FILLING;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else if (bus.clear) begin
            sum        <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            state      <= FILLING;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.sample_in_valid) begin
                sum        <= new_sum;
                wr_ptr     <= wr_ptr + 1'b1;
                fill_count <= fill_next;
                if (fill_next == FULL_COUNT) begin
                    state   <= PRIMED;
                    out_q   <= new_sum[SUM_W-1:LOG2_DEPTH];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ring[wr_ptr] <= bus.sample_in;
    end

    assign bus.filtered_out   = out_q;
    assign bus.filtered_valid = valid_q;
    assign bus.primed         = (state == PRIMED);
endmodule

// File: tb/tb_adc_reading_filter.sv
// Scoreboard bench for adc_reading_filter: a window model pushes expected means
// as samples are driven; a monitor pops and compares on every filtered_valid.
module tb_adc_reading_filter;
    localparam int DW = 12;
    localparam int L2 = 3;
    localparam int DEPTH = 1 << L2;

    logic clk = 1'b0;
    logic reset;

    adc_reading_filter_if #(.DATA_WIDTH(DW)) bus ();

    adc_reading_filter #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int win[$];
    int exp_q[$];
    int m_out = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Independent window model: recompute the mean from scratch each sample.
    task automatic model_sample(input int v);
        int s;
        win.push_back(v);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_out = s / DEPTH;
            exp_q.push_back(m_out);
        end
    endtask

    task automatic send(input int v);
        @(negedge clk);
        bus.sample_in       = DW'(v);
        bus.sample_in_valid = 1'b1;
        bus.clear           = 1'b0;
        model_sample(v);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        bus.clear           = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input int out, input bit prm);
        check({tag, "_out"}, 32'(bus.filtered_out), 32'(out));
        check({tag, "_primed"}, 32'(bus.primed), 32'(prm));
        check({tag, "_valid"}, 32'(bus.filtered_valid), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && bus.filtered_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("mean", 32'(bus.filtered_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset               = 1'b1;
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;
        bus.clear           = 1'b0;
        repeat (3) @(negedge clk);
        expect_state("reset", 0, 1'b0);
        reset = 1'b0;

        // 1: seven samples stay silent, the eighth produces the first mean
        repeat (7) send(100);
        idle(2);
        expect_state("fill7", 0, 1'b0);
        send(100);
        idle(2);
        expect_state("fill8", 100, 1'b1);

        // 2: full-scale samples back-to-back walk through the ring
        repeat (8) send(4095);
        idle(2);
        expect_state("fullscale", 4095, 1'b1);

        // 3: floor behaviour at the low end
        repeat (8) send(0);
        send(7);
        send(1);
        idle(2);
        expect_state("floor", 1, 1'b1);

        // 4: clear with a simultaneous sample drops the sample, output holds
        @(negedge clk);
        bus.sample_in       = DW'(500);
        bus.sample_in_valid = 1'b1;
        bus.clear           = 1'b1;
        win.delete();
        idle(1);
        expect_state("clear", 1, 1'b0);
        repeat (7) send(200);
        idle(2);
        expect_state("clear_fill7", 1, 1'b0);
        send(200);
        idle(2);
        expect_state("clear_fill8", 200, 1'b1);

        // 5: reset part-way through a fill
        idle(0);
        reset = 1'b1;
        win.delete();
        m_out = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) send(250);
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        reset = 1'b1;
        win.delete();
        m_out = 0;
        @(negedge clk);
        reset = 1'b0;
        expect_state("midreset", 0, 1'b0);
        repeat (7) send(300);
        idle(2);
        expect_state("reset_fill7", 0, 1'b0);
        send(300);
        idle(2);
        expect_state("reset_fill8", 300, 1'b1);

        // 6: gapped samples, output must hold between pulses
        for (int i = 0; i < 10; i++) begin
            send((i * 397 + 11) % 4096);
            idle(3);
            expect_state("gap_hold", m_out, 1'b1);
        end

        idle(3);
        check("pending_outputs", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
